// File: rtl/note_voice_scheduler.sv
// Polyphonic tone controller: several voices share one combinational note divider table
// through a round-robin scheduler, and each voice runs its own square-wave divider.
module note_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int CNT_W      = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7*NUM_VOICES-1:0]   note_i,
   input  logic [NUM_VOICES-1:0]     note_valid_i,
   output logic [6:0]                table_note_o,
   input  logic [CNT_W-1:0]          table_max_i,
   output logic [NUM_VOICES-1:0]     wave_o,
   output logic [NUM_VOICES-1:0]     loaded_o,
   output logic                      busy_o
);

   localparam int PTR_W = $clog2(NUM_VOICES);

   logic [6:0]        note_reg [NUM_VOICES];
   logic [CNT_W-1:0]  period   [NUM_VOICES];
   logic [CNT_W-1:0]  cnt      [NUM_VOICES];
   logic [NUM_VOICES-1:0] pending;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  grant_idx;
   logic              grant_valid;
   int                cand;

   // Walk the search order backwards so the candidate closest to rr_ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = NUM_VOICES - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_VOICES) cand = cand - NUM_VOICES;
         if (pending[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = PTR_W'(cand);
         end
      end
   end

   assign table_note_o = grant_valid ? note_reg[grant_idx] : 7'h00;
   assign busy_o       = |pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         pending  <= '0;
         wave_o   <= '0;
         loaded_o <= '0;
         rr_ptr   <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            note_reg[v] <= 7'h00;
            period[v]   <= '0;
            cnt[v]      <= '0;
         end
      end else begin
         loaded_o <= '0;
         if (grant_valid) begin
            if (grant_idx == PTR_W'(NUM_VOICES - 1)) rr_ptr <= '0;
            else                                     rr_ptr <= grant_idx + 1'b1;
         end
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (note_valid_i[v]) note_reg[v] <= note_i[7*v +: 7];
            if (grant_valid && grant_idx == PTR_W'(v)) begin
               // A strobe landing on the grant cycle keeps the voice pending for its new note.
               period[v]   <= table_max_i;
               cnt[v]      <= '0;
               wave_o[v]   <= 1'b0;
               loaded_o[v] <= 1'b1;
               pending[v]  <= note_valid_i[v];
            end else begin
               if (note_valid_i[v]) pending[v] <= 1'b1;
               if (period[v] == '0) begin
                  cnt[v]    <= '0;
                  wave_o[v] <= 1'b0;
               end else if (cnt[v] >= period[v]) begin
                  cnt[v]    <= '0;
                  wave_o[v] <= ~wave_o[v];
               end else begin
                  cnt[v]    <= cnt[v] + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_note_voice_scheduler.sv
// Directed bench for note_voice_scheduler: per-cycle vector table for arbitration,
// plus hand-written sequences for divider timing, silence, overwrite and mid-run reset.
module tb_note_voice_scheduler;

   localparam int NV = 4;
   localparam int CW = 20;

   logic             tb_clk = 1'b0;
   logic             rst;
   logic [7*NV-1:0]  note_i;
   logic [NV-1:0]    note_valid_i;
   logic [6:0]       table_note_o;
   logic [CW-1:0]    table_max_i;
   logic [NV-1:0]    wave_o;
   logic [NV-1:0]    loaded_o;
   logic             busy_o;

   int checks = 0;
   int passed = 0;

   always #5 tb_clk = ~tb_clk;

   note_voice_scheduler #(.NUM_VOICES(NV), .CNT_W(CW)) dut (
      .clk          (tb_clk),
      .rst          (rst),
      .note_i       (note_i),
      .note_valid_i (note_valid_i),
      .table_note_o (table_note_o),
      .table_max_i  (table_max_i),
      .wave_o       (wave_o),
      .loaded_o     (loaded_o),
      .busy_o       (busy_o)
   );

   function automatic logic [CW-1:0] tbl(input logic [6:0] n);
      case (n)
         7'h00:   tbl = 20'h0;
         7'h7C:   tbl = 20'h1F6;
         7'h7D:   tbl = 20'h1DA;
         7'h7E:   tbl = 20'h1BF;
         7'h7F:   tbl = 20'h1A6;
         default: tbl = CW'(n) * 20'd3 + 20'd5;
      endcase
   endfunction

   always_comb table_max_i = tbl(table_note_o);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      else passed++;
   endtask

   task automatic step();
      @(posedge tb_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      note_valid_i = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_level(input int idx, input logic lvl, input int budget, output int n);
      n = 0;
      while (wave_o[idx] !== lvl && n < budget) begin
         step();
         n++;
      end
   endtask

   typedef struct {
      logic [NV-1:0]   valid;
      logic [7*NV-1:0] notes;
      logic [6:0]      exp_tn;
      logic [NV-1:0]   exp_ld;
      logic            exp_busy;
   } vec_t;

   vec_t vecs [11];
   int   n;
   int   cnt_bad;

   initial begin
      // Inputs applied in a row are sampled at that row's closing edge; expected outputs
      // are what the registers show during that row.
      vecs[0]  = '{4'hF, {7'h7F, 7'h7E, 7'h7D, 7'h7C}, 7'h00, 4'h0, 1'b0};
      vecs[1]  = '{4'h0, 28'h0,                        7'h7C, 4'h0, 1'b1};
      vecs[2]  = '{4'h0, 28'h0,                        7'h7D, 4'h1, 1'b1};
      vecs[3]  = '{4'h0, 28'h0,                        7'h7E, 4'h2, 1'b1};
      vecs[4]  = '{4'h0, 28'h0,                        7'h7F, 4'h4, 1'b1};
      vecs[5]  = '{4'h0, 28'h0,                        7'h00, 4'h8, 1'b0};
      vecs[6]  = '{4'h2, {7'h00, 7'h00, 7'h10, 7'h00}, 7'h00, 4'h0, 1'b0};
      vecs[7]  = '{4'h5, {7'h00, 7'h30, 7'h00, 7'h20}, 7'h10, 4'h0, 1'b1};
      vecs[8]  = '{4'h0, 28'h0,                        7'h30, 4'h2, 1'b1};
      vecs[9]  = '{4'h0, 28'h0,                        7'h20, 4'h4, 1'b1};
      vecs[10] = '{4'h0, 28'h0,                        7'h00, 4'h1, 1'b0};

      // Reset held two cycles with all strobes active.
      rst = 1'b1;
      note_valid_i = 4'hF;
      note_i = {7'h11, 7'h22, 7'h33, 7'h44};
      step();
      step();
      chk("rst_table_note", 32'(table_note_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_loaded", 32'(loaded_o), 32'h0);
      chk("rst_wave", 32'(wave_o), 32'h0);
      rst = 1'b0;
      note_valid_i = '0;
      step();
      chk("rst_release_loaded", 32'(loaded_o), 32'h0);
      chk("rst_release_busy", 32'(busy_o), 32'h0);

      // Contention and fairness vectors.
      for (int i = 0; i < 11; i++) begin
         note_valid_i = vecs[i].valid;
         note_i       = vecs[i].notes;
         chk($sformatf("vec%0d_table_note", i), 32'(table_note_o), 32'(vecs[i].exp_tn));
         chk($sformatf("vec%0d_loaded", i), 32'(loaded_o), 32'(vecs[i].exp_ld));
         chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_wave", i), 32'(wave_o), 32'h0);
         step();
      end

      // Single voice: note 7E -> period 447, half-period 448 cycles.
      do_reset();
      note_valid_i = 4'h1;
      note_i = {21'h0, 7'h7E};
      step();
      note_valid_i = '0;
      chk("single_table_note", 32'(table_note_o), 32'h7E);
      step();
      chk("single_loaded", 32'(loaded_o), 32'h1);
      wait_level(0, 1'b1, 1000, n);
      chk("single_first_rise", 32'(n), 32'd448);
      wait_level(0, 1'b0, 1000, n);
      chk("single_half_period", 32'(n), 32'd448);

      // Silence: note 0 gives period 0 and a wave stuck low.
      do_reset();
      note_valid_i = 4'h8;
      note_i = {7'h00, 21'h0};
      step();
      note_valid_i = '0;
      chk("silence_table_note", 32'(table_note_o), 32'h00);
      chk("silence_busy", 32'(busy_o), 32'h1);
      step();
      chk("silence_loaded", 32'(loaded_o), 32'h8);
      cnt_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (wave_o[3] !== 1'b0) cnt_bad++;
      end
      chk("silence_wave_high_cycles", 32'(cnt_bad), 32'd0);

      // Overwrite on the grant cycle: old note loads, new note is re-granted.
      note_valid_i = 4'h8;
      note_i = {7'h00, 21'h0};
      step();
      chk("ovw_grant_note", 32'(table_note_o), 32'h00);
      note_valid_i = 4'h8;
      note_i = {7'h7F, 21'h0};
      step();
      note_valid_i = '0;
      chk("ovw_first_loaded", 32'(loaded_o), 32'h8);
      chk("ovw_regrant_note", 32'(table_note_o), 32'h7F);
      chk("ovw_still_busy", 32'(busy_o), 32'h1);
      step();
      chk("ovw_second_loaded", 32'(loaded_o), 32'h8);
      chk("ovw_idle_busy", 32'(busy_o), 32'h0);
      wait_level(3, 1'b1, 1000, n);
      chk("ovw_first_rise", 32'(n), 32'd423);

      // Mid-run reset with voice0 toggling and voice2 pending.
      do_reset();
      note_valid_i = 4'h1;
      note_i = {21'h0, 7'h01};
      step();
      note_valid_i = '0;
      step();
      chk("midrst_loaded", 32'(loaded_o), 32'h1);
      wait_level(0, 1'b1, 100, n);
      chk("midrst_v0_rise", 32'(n), 32'd9);
      note_valid_i = 4'h4;
      note_i = {7'h00, 7'h22, 14'h0};
      step();
      note_valid_i = '0;
      chk("midrst_v2_grant", 32'(table_note_o), 32'h22);
      chk("midrst_v2_busy", 32'(busy_o), 32'h1);
      rst = 1'b1;
      step();
      chk("midrst_wave", 32'(wave_o), 32'h0);
      chk("midrst_busy", 32'(busy_o), 32'h0);
      chk("midrst_loaded_none", 32'(loaded_o), 32'h0);
      chk("midrst_table_note", 32'(table_note_o), 32'h0);
      rst = 1'b0;
      cnt_bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (loaded_o !== '0 || busy_o !== 1'b0) cnt_bad++;
      end
      chk("midrst_no_late_load", 32'(cnt_bad), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
